// File: rtl/laser_pkg.sv
// Shared definitions for the laser-controller count upload path.
// - Record layout: {err[3:0], count[31:0]} in a 36-bit word.
// - Status byte layout: {overflow, 3'b000, err[3:0]}.
// - Framing FSM state encoding.
package laser_pkg;

    localparam int unsigned RecW       = 36;
    localparam int unsigned CntW       = 32;
    localparam int unsigned ErrW       = 4;
    localparam int unsigned ErrLsb     = 32;
    localparam int unsigned StatOvfBit = 7;

    typedef enum logic [1:0] {
        StIdle,
        StHdr,
        StRec,
        StDone
    } upl_state_e;

    function automatic logic [7:0] status_byte(input logic ovf, input logic [ErrW-1:0] err);
        logic [7:0] s;
        s             = '0;
        s[ErrW-1:0]   = err;
        s[StatOvfBit] = ovf;
        return s;
    endfunction

endpackage

// File: rtl/count_fifo.sv
// Synchronous record FIFO (DEPTH x RecW) with registered read.
// Ports:
//   clk_i, rst_i  clock, asynchronous active-high reset
//   clr_i         synchronous flush (wins over a simultaneous write/read)
//   wr_en_i       write request; ignored when full
//   wr_data_i     record to store
//   rd_en_i       pop request; ignored when empty; rd_data_o updates on the same edge
//   rd_data_o     last popped record
//   full_o        FIFO holds DEPTH records
//   empty_o       FIFO holds no records
//   level_o       records currently stored
module count_fifo
    import laser_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            clr_i,
    input  logic            wr_en_i,
    input  logic [RecW-1:0] wr_data_i,
    input  logic            rd_en_i,
    output logic [RecW-1:0] rd_data_o,
    output logic            full_o,
    output logic            empty_o,
    output logic [AW:0]     level_o
);

    logic [RecW-1:0] mem_q [DEPTH];
    logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
    logic [AW:0]     level_q, level_d;
    logic [RecW-1:0] rd_data_q;
    logic            do_wr, do_rd;

    assign full_o    = (level_q == (AW+1)'(DEPTH));
    assign empty_o   = (level_q == '0);
    assign level_o   = level_q;
    assign rd_data_o = rd_data_q;

    assign do_wr = wr_en_i & ~full_o & ~clr_i;
    assign do_rd = rd_en_i & ~empty_o & ~clr_i;

    always_comb begin
        level_d = level_q;
        unique case ({do_wr, do_rd})
            2'b10:   level_d = level_q + 1'b1;
            2'b01:   level_d = level_q - 1'b1;
            default: level_d = level_q;
        endcase
        if (clr_i) begin
            level_d = '0;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            level_q   <= '0;
            rd_data_q <= '0;
        end else begin
            level_q <= level_d;
            if (clr_i) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
            end else begin
                if (do_wr) wr_ptr_q <= wr_ptr_q + 1'b1;
                if (do_rd) begin
                    rd_ptr_q  <= rd_ptr_q + 1'b1;
                    rd_data_q <= mem_q[rd_ptr_q];
                end
            end
        end
    end

    // Storage array carries no reset.
    always_ff @(posedge clk_i) begin
        if (do_wr) mem_q[wr_ptr_q] <= wr_data_i;
    end

endmodule

// File: rtl/count_data_uploader.sv
// Buffers PMT count records with their lock error flags and, on a SENDDATA request,
// streams them to the PC transmitter as: header N, then 5 bytes per record
// (count MSB first, then status). Returns oFinishedSendingData once done.
// Ports:
//   iCLOCK, iRESET          clock, asynchronous active-high reset
//   iCountReady/Data        count record write strobe and value
//   iErrorSignal            lock error flags captured with the count
//   iSendData               upload request level
//   oFinishedSendingData    upload complete, held until iSendData falls
//   oTxData/oTxValid/iTxReady  byte stream to the PC transmitter
//   iClearBuffer            synchronous flush and abort
//   oFifoLevel              records stored
//   oOverflow               sticky dropped-record flag
module count_data_uploader
    import laser_pkg::*;
#(
    parameter int unsigned DEPTH = 64,
    parameter int unsigned AW    = 6
) (
    input  logic            iCLOCK,
    input  logic            iRESET,
    input  logic            iCountReady,
    input  logic [CntW-1:0] iCountData,
    input  logic [ErrW-1:0] iErrorSignal,
    input  logic            iSendData,
    output logic            oFinishedSendingData,
    output logic [7:0]      oTxData,
    output logic            oTxValid,
    input  logic            iTxReady,
    input  logic            iClearBuffer,
    output logic [AW:0]     oFifoLevel,
    output logic            oOverflow
);

    localparam logic [2:0] StatIdx = 3'd4;

    upl_state_e      state_q, state_d;
    logic [AW:0]     rem_q, rem_d;
    logic [2:0]      idx_q, idx_d;
    logic            ovf_q, ovf_d;
    logic            pop;
    logic            accept;
    logic            fifo_full, fifo_empty;
    logic [RecW-1:0] rd_rec;

    count_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_fifo (
        .clk_i     (iCLOCK),
        .rst_i     (iRESET),
        .clr_i     (iClearBuffer),
        .wr_en_i   (iCountReady),
        .wr_data_i ({iErrorSignal, iCountData}),
        .rd_en_i   (pop & ~fifo_empty),
        .rd_data_o (rd_rec),
        .full_o    (fifo_full),
        .empty_o   (fifo_empty),
        .level_o   (oFifoLevel)
    );

    assign oTxValid             = (state_q == StHdr) || (state_q == StRec);
    assign oFinishedSendingData = (state_q == StDone);
    assign oOverflow            = ovf_q;
    assign accept               = oTxValid & iTxReady;

    // Byte mux reads straight from the registered FIFO output, so the pop issued on
    // the header/status accept makes count[31:24] available with no bubble.
    always_comb begin
        oTxData = '0;
        unique case (state_q)
            StHdr: oTxData = 8'(rem_q);
            StRec: begin
                unique case (idx_q)
                    3'd0:    oTxData = rd_rec[31:24];
                    3'd1:    oTxData = rd_rec[23:16];
                    3'd2:    oTxData = rd_rec[15:8];
                    3'd3:    oTxData = rd_rec[7:0];
                    default: oTxData = status_byte(ovf_q, rd_rec[ErrLsb +: ErrW]);
                endcase
            end
            default: oTxData = '0;
        endcase
    end

    always_comb begin
        state_d = state_q;
        rem_d   = rem_q;
        idx_d   = idx_q;
        pop     = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (iSendData) begin
                    rem_d   = oFifoLevel;
                    idx_d   = '0;
                    state_d = StHdr;
                end
            end
            StHdr: begin
                if (accept) begin
                    if (rem_q == '0) begin
                        state_d = StDone;
                    end else begin
                        pop     = 1'b1;
                        idx_d   = '0;
                        state_d = StRec;
                    end
                end
            end
            StRec: begin
                if (accept) begin
                    if (idx_q != StatIdx) begin
                        idx_d = idx_q + 3'd1;
                    end else begin
                        rem_d = rem_q - 1'b1;
                        idx_d = '0;
                        if (rem_q != (AW+1)'(1)) begin
                            pop = 1'b1;
                        end else begin
                            state_d = StDone;
                        end
                    end
                end
            end
            StDone: begin
                if (!iSendData) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
        if (iClearBuffer) begin
            state_d = StIdle;
            rem_d   = '0;
            idx_d   = '0;
            pop     = 1'b0;
        end
    end

    always_comb begin
        ovf_d = ovf_q | (iCountReady & fifo_full);
        if (iClearBuffer) ovf_d = 1'b0;
    end

    always_ff @(posedge iCLOCK or posedge iRESET) begin
        if (iRESET) begin
            state_q <= StIdle;
            rem_q   <= '0;
            idx_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rem_q   <= rem_d;
            idx_q   <= idx_d;
            ovf_q   <= ovf_d;
        end
    end

endmodule

// File: tb/tb_count_data_uploader.sv
module tb_count_data_uploader;

    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic        iCLOCK = 1'b0;
    logic        iRESET;
    logic        iCountReady;
    logic [31:0] iCountData;
    logic [3:0]  iErrorSignal;
    logic        iSendData;
    logic        oFinishedSendingData;
    logic [7:0]  oTxData;
    logic        oTxValid;
    logic        iTxReady;
    logic        iClearBuffer;
    logic [AW:0] oFifoLevel;
    logic        oOverflow;

    count_data_uploader #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .iCLOCK               (iCLOCK),
        .iRESET               (iRESET),
        .iCountReady          (iCountReady),
        .iCountData           (iCountData),
        .iErrorSignal         (iErrorSignal),
        .iSendData            (iSendData),
        .oFinishedSendingData (oFinishedSendingData),
        .oTxData              (oTxData),
        .oTxValid             (oTxValid),
        .iTxReady             (iTxReady),
        .iClearBuffer         (iClearBuffer),
        .oFifoLevel           (oFifoLevel),
        .oOverflow            (oOverflow)
    );

    always #10 iCLOCK = ~iCLOCK;

    int n_checks = 0;
    int n_fail   = 0;

    logic [35:0] mq[$];     // model FIFO contents
    logic        m_ovf = 1'b0;
    logic [7:0]  exp_q[$];  // scoreboard of expected bytes

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge iCLOCK);
        #1;
    endtask

    task automatic model_write(input logic [31:0] d, input logic [3:0] e);
        if (mq.size() < DEPTH) mq.push_back({e, d});
        else m_ovf = 1'b1;
    endtask

    task automatic write_rec(input logic [31:0] d, input logic [3:0] e);
        iCountReady  = 1'b1;
        iCountData   = d;
        iErrorSignal = e;
        tick();
        iCountReady  = 1'b0;
        model_write(d, e);
    endtask

    // Runs one full upload. inject_k >= 0 pulses iCountReady on the accept of byte inject_k.
    task automatic do_upload(input string tag, input bit rnd, input int inject_k);
        int          n, got, cyc, exp_n;
        logic [35:0] r;
        logic [7:0]  e, held_d;
        bit          held, inj;
        n = mq.size();
        exp_q.push_back(8'(n));
        for (int i = 0; i < n; i++) begin
            r = mq.pop_front();
            exp_q.push_back(r[31:24]);
            exp_q.push_back(r[23:16]);
            exp_q.push_back(r[15:8]);
            exp_q.push_back(r[7:0]);
            exp_q.push_back({m_ovf, 3'b000, r[35:32]});
        end
        exp_n = exp_q.size();
        got = 0;
        cyc = 0;
        inj = 1'b0;
        iTxReady  = 1'b1;
        iSendData = 1'b1;
        tick();
        check_eq({tag, "_hdr_valid"}, oTxValid, 1'b1);
        while (got < exp_n && cyc < 4000) begin
            iTxReady = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            held = 1'b0;
            held_d = '0;
            if (oTxValid && iTxReady) begin
                e = exp_q.pop_front();
                check_eq({tag, "_byte"}, oTxData, e);
                if (got == inject_k) begin
                    iCountReady  = 1'b1;
                    iCountData   = 32'hCAFE_0042;
                    iErrorSignal = 4'h3;
                    inj = 1'b1;
                end
                got++;
            end else if (oTxValid) begin
                held   = 1'b1;
                held_d = oTxData;
            end
            tick();
            cyc++;
            if (held && oTxValid) check_eq({tag, "_hold"}, oTxData, held_d);
            if (inj) begin
                iCountReady = 1'b0;
                model_write(32'hCAFE_0042, 4'h3);
                inj = 1'b0;
            end
        end
        if (got < exp_n) begin
            check_eq({tag, "_timeout"}, got, exp_n);
            exp_q.delete();
        end
        if (!rnd) check_eq({tag, "_cycles"}, cyc, exp_n);
        check_eq({tag, "_fin_rise"}, oFinishedSendingData, 1'b1);
        check_eq({tag, "_done_novalid"}, oTxValid, 1'b0);
        iSendData = 1'b0;
        #1;
        check_eq({tag, "_fin_held"}, oFinishedSendingData, 1'b1);
        tick();
        check_eq({tag, "_fin_fall"}, oFinishedSendingData, 1'b0);
        iTxReady = 1'b1;
    endtask

    // Writes 3 records and advances into REC with two bytes of the first record sent.
    task automatic start_partial();
        write_rec(32'h0000_00AA, 4'h1);
        write_rec(32'h0000_00BB, 4'h2);
        write_rec(32'h0000_00CC, 4'h4);
        iTxReady  = 1'b1;
        iSendData = 1'b1;
        tick();
        tick();
        tick();
        tick();
        iTxReady  = 1'b0;
        check_eq("partial_in_rec", oTxValid, 1'b1);
        check_eq("partial_byte", oTxData, 8'h00);
    endtask

    initial begin
        iRESET       = 1'b1;
        iCountReady  = 1'b0;
        iCountData   = '0;
        iErrorSignal = '0;
        iSendData    = 1'b0;
        iTxReady     = 1'b0;
        iClearBuffer = 1'b0;
        tick();
        tick();
        check_eq("rst_txdata", oTxData, 8'h00);
        check_eq("rst_txvalid", oTxValid, 1'b0);
        check_eq("rst_fin", oFinishedSendingData, 1'b0);
        check_eq("rst_level", oFifoLevel, 0);
        check_eq("rst_ovf", oOverflow, 1'b0);
        @(negedge iCLOCK);
        iRESET = 1'b0;
        tick();

        // Basic three-record upload.
        write_rec(32'h1234_5678, 4'h0);
        check_eq("level_after_write", oFifoLevel, 1);
        write_rec(32'h0000_0001, 4'h5);
        write_rec(32'hFFFF_FFFF, 4'hF);
        check_eq("level_3", oFifoLevel, 3);
        do_upload("basic", 1'b0, -1);
        check_eq("level_after_basic", oFifoLevel, 0);

        // Same data under random back-pressure.
        write_rec(32'h1234_5678, 4'h0);
        write_rec(32'h0000_0001, 4'h5);
        write_rec(32'hFFFF_FFFF, 4'hF);
        do_upload("rand", 1'b1, -1);

        // Empty upload: header 00 only.
        do_upload("empty", 1'b0, -1);

        // Write coinciding with the header-accept pop.
        write_rec(32'hA5A5_0001, 4'h8);
        write_rec(32'h5A5A_0002, 4'h9);
        do_upload("inject", 1'b0, 0);
        check_eq("inject_level", oFifoLevel, 1);
        do_upload("inject2", 1'b0, -1);

        // Overflow: 65 writes into a 64-deep FIFO.
        for (int i = 0; i < DEPTH + 1; i++) write_rec(32'h100 + 32'(i), 4'(i));
        check_eq("ovf_level", oFifoLevel, DEPTH);
        check_eq("ovf_flag", oOverflow, 1'b1);
        do_upload("ovf", 1'b0, -1);
        check_eq("ovf_sticky", oOverflow, 1'b1);

        // Clear mid-REC.
        start_partial();
        iClearBuffer = 1'b1;
        iSendData    = 1'b0;
        tick();
        iClearBuffer = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        check_eq("clr_txvalid", oTxValid, 1'b0);
        check_eq("clr_level", oFifoLevel, 0);
        check_eq("clr_ovf", oOverflow, 1'b0);
        tick();
        check_eq("clr_idle", oTxValid, 1'b0);
        do_upload("after_clr", 1'b0, -1);

        // Reset mid-REC.
        start_partial();
        #2;
        iRESET = 1'b1;
        #1;
        check_eq("rst_mid_txvalid", oTxValid, 1'b0);
        check_eq("rst_mid_level", oFifoLevel, 0);
        check_eq("rst_mid_ovf", oOverflow, 1'b0);
        check_eq("rst_mid_fin", oFinishedSendingData, 1'b0);
        iSendData = 1'b0;
        mq.delete();
        m_ovf = 1'b0;
        @(negedge iCLOCK);
        iRESET = 1'b0;
        tick();
        do_upload("after_rst", 1'b0, -1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
